// File: rtl/duck_pkg.sv
// duck_pkg: shared FSM state type and default timing/shot constants for the light gun
package duck_pkg;
   typedef enum logic [2:0] {IDLE, ARM, DARK, LIGHT, RESULT, HOLD} state_t;
   localparam int DEBOUNCE_CYCLES = 250000;
   localparam int MIN_LIGHT_CYCLES = 16;
   localparam int SHOTS = 3;
endpackage

// File: rtl/debounce.sv
// debounce: two-flop synchroniser followed by a stable-for-N-cycles level filter
module debounce #(
   parameter int DEBOUNCE_CYCLES = duck_pkg::DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk)
      if (rst) begin
         sync <= '0;
         cnt <= '0;
         dout <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         if (sync[1] == dout) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            dout <= sync[1];
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/gun_ctrl.sv
// gun_ctrl: light-gun shot sequencer -- debounced trigger, dark/light frame sensing, score and ammo
module gun_ctrl #(
   parameter int DEBOUNCE_CYCLES = duck_pkg::DEBOUNCE_CYCLES,
   parameter int MIN_LIGHT_CYCLES = duck_pkg::MIN_LIGHT_CYCLES,
   parameter int SHOTS = duck_pkg::SHOTS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trigger_raw,
   input  logic       sensor_raw,
   input  logic       frame_start,
   input  logic       valid,
   input  logic       reload,
   output logic       trigger,
   output logic       hit,
   output logic       miss,
   output logic [7:0] score,
   output logic [1:0] shots_left
);
   import duck_pkg::*;
   localparam int LW = $clog2(MIN_LIGHT_CYCLES + 1);
   localparam logic [LW-1:0] LMAX = LW'(MIN_LIGHT_CYCLES);
   state_t state, state_n;
   logic db, fs_q, fe, lit, accept, is_hit;
   logic [1:0] sensor_sync;
   logic [LW-1:0] dark_cnt, light_cnt;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk(clk), .rst(rst), .din(trigger_raw), .dout(db)
   );

   assign fe = frame_start & ~fs_q;
   assign lit = valid & sensor_sync[1];
   // reload takes priority: a coinciding press waits one cycle so the decrement is not lost
   assign accept = state == IDLE && db && shots_left != 2'd0 && !reload;
   assign is_hit = dark_cnt < LMAX && light_cnt == LMAX;

   always_comb begin
      state_n = state;
      trigger = state != IDLE;
      hit = state == RESULT && is_hit;
      miss = state == RESULT && !is_hit;
      case (state)
         IDLE:    state_n = accept ? ARM : IDLE;
         ARM:     state_n = fe ? DARK : ARM;
         DARK:    state_n = fe ? LIGHT : DARK;
         LIGHT:   state_n = fe ? RESULT : LIGHT;
         RESULT:  state_n = HOLD;
         HOLD:    state_n = db ? HOLD : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         fs_q <= 1'b0;
         sensor_sync <= '0;
         dark_cnt <= '0;
         light_cnt <= '0;
         score <= '0;
         shots_left <= 2'(SHOTS);
      end else begin
         state <= state_n;
         fs_q <= frame_start;
         sensor_sync <= {sensor_sync[0], sensor_raw};
         if (accept) begin
            dark_cnt <= '0;
            light_cnt <= '0;
         end else begin
            if (state == DARK && lit && dark_cnt != LMAX) dark_cnt <= dark_cnt + 1'b1;
            if (state == LIGHT && lit && light_cnt != LMAX) light_cnt <= light_cnt + 1'b1;
         end
         if (hit && score != 8'hFF) score <= score + 8'd1;
         shots_left <= reload ? 2'(SHOTS) : accept ? shots_left - 2'd1 : shots_left;
      end
endmodule
